ifetch_ctrl: RTL and testbench
==============================

Name: ifetch_ctrl

Overview:
- Instruction fetch controller that sequences the byte-addressed, combinational-read instruction memory.
- Holds the program counter and drives the memory word address each cycle.
- Captures returned instructions into a small prefetch FIFO and hands them to decode over a valid/ready handshake.
- Handles redirects (branch/jump) by flushing the FIFO and restarting fetch at the new PC after a one-cycle bubble.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; low two bits are forced to 0.
- FIFO_DEPTH, 4, prefetch entries; must be a power of 2 and at least 2.
- CNT_W, 3, width of fifo_count; must satisfy 2^CNT_W > FIFO_DEPTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- fetch_en  input  1  permits new memory fetches; low pauses fetch but FIFO still drains.
- redirect_valid  input  1  one-cycle pulse; flush the FIFO and load redirect_pc.
- redirect_pc  input  32  new fetch address; bits [1:0] are ignored and treated as 0.
- imem_addr  output  32  byte address to instruction memory; always equals the PC register (combinational from the register).
- imem_data  input  32  instruction word returned combinationally for imem_addr in the same cycle.
- instr_valid  output  1  FIFO head holds a valid instruction.
- instr_ready  input  1  decode accepts the head this cycle.
- instr_out  output  32  FIFO head instruction.
- instr_pc  output  32  PC of the FIFO head instruction.
- fifo_count  output  CNT_W  number of occupied entries, 0..FIFO_DEPTH.

Behaviour:
- Reset (synchronous, rst=1 at a clock edge):
  - pc=RESET_PC with bits [1:0] cleared; FIFO empty; fifo_count=0; state=IDLE.
  - instr_valid=0; instr_out=0 and instr_pc=0 whenever empty.
  - Reset overrides every other input, including a redirect in the same cycle, and mid-operation it discards all FIFO contents.
- States: IDLE, FETCH, FLUSH.
  - IDLE: no push. If fetch_en=1, next state is FETCH.
  - FETCH: push when fetch_en=1 and (fifo_count<FIFO_DEPTH or a pop occurs this cycle). If fetch_en=0, next state is IDLE.
  - FLUSH: exactly one bubble cycle with no push. Next state is FETCH if fetch_en=1, otherwise IDLE.
- Push: the FIFO stores {imem_data, pc} and pc advances by 4, modulo 2^32. 32'hFFFF_FFFC wraps to 0. Memory aliasing above its size is not this block's concern.
- Pop: occurs when instr_valid && instr_ready. The head advances at the clock edge.
- Push and pop in the same cycle: fifo_count is unchanged. This is legal at full, because a pop frees the slot.
- instr_valid = (fifo_count != 0). instr_out and instr_pc are driven from FIFO storage, so data is visible the cycle after the push edge.
- Latency: the first instr_valid appears 2 cycles after the first post-reset edge with fetch_en=1 (one cycle in IDLE, one push in FETCH). Steady-state throughput is 1 instruction per cycle when instr_ready is held high.
- Redirect (redirect_valid=1, rst=0): takes priority over push.
  - A pop handshake in the same cycle still completes (decode consumed the head).
  - The FIFO is cleared, pc={redirect_pc[31:2],2'b00}, and state=FLUSH.
  - instr_valid=0 the next cycle.
  - The first redirected instruction becomes valid 2 cycles after the redirect edge.
  - Back-to-back redirects: the last one wins, and each restarts FLUSH.
- Empty: instr_out and instr_pc are held at 0; instr_ready is ignored.
- Full with no pop: no push and pc holds; imem_addr stays stable.
- fetch_en low: pc holds and the FIFO drains normally.

Test Plan:
1. Reset with RESET_PC=0, then fetch_en=1 and instr_ready=1. Memory holds 0x11111111 at 0x0 and 0x22222222 at 0x4. Required: instr_valid rises on the 2nd cycle with instr_out=0x11111111 and instr_pc=0x0; the next cycle gives 0x22222222 / 0x4; one instruction per cycle thereafter.
2. Back-pressure: instr_ready=0 with fetch_en=1. Required: fifo_count reaches 4, imem_addr freezes at 0x10, and the head stays pc 0x0. Raise instr_ready for 1 cycle: the head becomes 0x4, fifo_count stays 4, and imem_addr becomes 0x14.
3. Redirect with FIFO holding pcs 0x8..0x14: pulse redirect_valid with redirect_pc=0x43. Required: next cycle instr_valid=0, fifo_count=0, imem_addr=0x40; 2 cycles after the redirect, instr_pc=0x40.
4. Redirect coincident with an accepted pop of pc 0x8. Required: the pop completes, then the FIFO is empty. Consecutive redirects to 0x100 then 0x200 must fetch only from 0x200.
5. PC wrap: redirect to 0xFFFFFFFC. Required: consecutive instr_pc values are 0xFFFFFFFC then 0x00000000.
6. Mid-run reset with 3 entries queued and a redirect pulse in the same cycle. Required: after the edge, fifo_count=0, instr_valid=0, imem_addr=RESET_PC, state IDLE; the redirect is ignored.

Source files
------------

// File: rtl/ifetch_ctrl.sv
// Instruction fetch controller: owns the PC, drives a combinational-read
// instruction memory and buffers returned words in a small prefetch FIFO.
module ifetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4,
  parameter int          CNT_W      = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fetch_en,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_data,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [31:0]      instr_out,
  output logic [31:0]      instr_pc,
  output logic [CNT_W-1:0] fifo_count
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [31:0]      pc;
  logic [31:0]      data_mem [FIFO_DEPTH];
  logic [31:0]      pc_mem   [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             not_full;
  logic             push;
  logic             pop;

  assign imem_addr   = pc;
  assign fifo_count  = count;
  assign instr_valid = (count != '0);
  assign instr_out   = instr_valid ? data_mem[rd_ptr] : 32'h0;
  assign instr_pc    = instr_valid ? pc_mem[rd_ptr]   : 32'h0;
  assign not_full    = (count < CNT_W'(FIFO_DEPTH));
  assign pop         = instr_valid && instr_ready;

  // A redirect suppresses the push; a pop frees a slot even when full.
  always_comb begin
    push       = 1'b0;
    state_next = state;
    if (redirect_valid) begin
      state_next = FLUSH;
    end else begin
      state_next = fetch_en ? FETCH : IDLE;
      if (state == FETCH && fetch_en && (not_full || pop)) begin
        push = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      pc     <= RESET_PC_ALIGNED;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      state <= state_next;
      if (redirect_valid) begin
        pc     <= {redirect_pc[31:2], 2'b00};
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          pc     <= pc + 32'd4;
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        if (push && !pop) begin
          count <= count + CNT_W'(1);
        end else if (pop && !push) begin
          count <= count - CNT_W'(1);
        end
      end
    end
  end

  // Storage needs no reset; occupancy is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      data_mem[wr_ptr] <= imem_data;
      pc_mem[wr_ptr]   <= pc;
    end
  end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed bench for ifetch_ctrl: a small combinational memory model feeds
// imem_data and every step is checked against hand-computed values.
module tb_ifetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic [2:0]  fifo_count;

  int passCount = 0;
  int totalCount = 0;

  always #5 clk = ~clk;

  // Memory contents: two fixed words at 0x0/0x4, an address-derived pattern elsewhere.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (a == 32'h0) return 32'h1111_1111;
    if (a == 32'h4) return 32'h2222_2222;
    return a ^ 32'hA5A5_0000;
  endfunction

  assign imem_data = memWord(imem_addr);

  ifetch_ctrl #(
    .RESET_PC(32'h0000_0000),
    .FIFO_DEPTH(4),
    .CNT_W(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .fetch_en(fetch_en),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .imem_addr(imem_addr),
    .imem_data(imem_data),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr_out(instr_out),
    .instr_pc(instr_pc),
    .fifo_count(fifo_count)
  );

  // Drive inputs, then advance one clock and settle past the edge.
  task automatic applyStimulus(input logic r, input logic en, input logic rdy,
                               input logic rv, input logic [31:0] rpc);
    rst            = r;
    fetch_en       = en;
    instr_ready    = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    totalCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s observed=%08h expected=%08h", tag, observed, expected);
  endtask

  initial begin
    rst = 1'b1; fetch_en = 1'b0; instr_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0;

    // Reset state
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("rst_count", 32'(fifo_count), 32'd0);
    checkOutput("rst_valid", 32'(instr_valid), 32'd0);
    checkOutput("rst_addr", imem_addr, 32'h0);
    checkOutput("rst_out", instr_out, 32'h0);
    checkOutput("rst_pc", instr_pc, 32'h0);

    // Test 1: first fetch latency and streaming
    applyStimulus(0, 1, 1, 0, 0);
    checkOutput("t1_valid_c1", 32'(instr_valid), 32'd0);
    applyStimulus(0, 1, 1, 0, 0);
    checkOutput("t1_valid_c2", 32'(instr_valid), 32'd1);
    checkOutput("t1_out0", instr_out, 32'h1111_1111);
    checkOutput("t1_pc0", instr_pc, 32'h0);
    applyStimulus(0, 1, 1, 0, 0);
    checkOutput("t1_out1", instr_out, 32'h2222_2222);
    checkOutput("t1_pc1", instr_pc, 32'h4);
    checkOutput("t1_count1", 32'(fifo_count), 32'd1);
    applyStimulus(0, 1, 1, 0, 0);
    checkOutput("t1_out2", instr_out, 32'hA5A5_0008);
    checkOutput("t1_pc2", instr_pc, 32'h8);

    // Test 2: back-pressure from a fresh reset
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("t2_rst_count", 32'(fifo_count), 32'd0);
    for (int i = 0; i < 6; i++) applyStimulus(0, 1, 0, 0, 0);
    checkOutput("t2_full_count", 32'(fifo_count), 32'd4);
    checkOutput("t2_full_addr", imem_addr, 32'h10);
    checkOutput("t2_full_head", instr_pc, 32'h0);
    applyStimulus(0, 1, 1, 0, 0);
    checkOutput("t2_pop_head", instr_pc, 32'h4);
    checkOutput("t2_pop_count", 32'(fifo_count), 32'd4);
    checkOutput("t2_pop_addr", imem_addr, 32'h14);

    // Test 3: redirect with FIFO holding 0x8..0x14
    applyStimulus(0, 1, 1, 0, 0);
    checkOutput("t3_pre_head", instr_pc, 32'h8);
    applyStimulus(0, 1, 0, 1, 32'h43);
    checkOutput("t3_valid", 32'(instr_valid), 32'd0);
    checkOutput("t3_count", 32'(fifo_count), 32'd0);
    checkOutput("t3_addr", imem_addr, 32'h40);
    checkOutput("t3_out_empty", instr_out, 32'h0);
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("t3_bubble", 32'(instr_valid), 32'd0);
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("t3_new_pc", instr_pc, 32'h40);
    checkOutput("t3_new_out", instr_out, 32'hA5A5_0040);

    // Test 4: redirect with a coincident pop, then back-to-back redirects
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0, 0);
    checkOutput("t4_full", 32'(fifo_count), 32'd4);
    applyStimulus(0, 1, 1, 1, 32'h100);
    checkOutput("t4_flush_count", 32'(fifo_count), 32'd0);
    checkOutput("t4_addr100", imem_addr, 32'h100);
    applyStimulus(0, 1, 0, 1, 32'h200);
    checkOutput("t4_addr200", imem_addr, 32'h200);
    checkOutput("t4_count_b2b", 32'(fifo_count), 32'd0);
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("t4_bubble", 32'(instr_valid), 32'd0);
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("t4_head200", instr_pc, 32'h200);
    checkOutput("t4_count1", 32'(fifo_count), 32'd1);

    // Test 5: PC wrap
    applyStimulus(0, 1, 0, 1, 32'hFFFF_FFFC);
    checkOutput("t5_addr", imem_addr, 32'hFFFF_FFFC);
    applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("t5_head", instr_pc, 32'hFFFF_FFFC);
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("t5_wrap_addr", imem_addr, 32'h4);
    applyStimulus(0, 1, 1, 0, 0);
    checkOutput("t5_next_pc", instr_pc, 32'h0);
    checkOutput("t5_next_out", instr_out, 32'h1111_1111);

    // Test 6: reset overrides a coincident redirect with entries queued
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("t6_queued", 32'(fifo_count), 32'd3);
    applyStimulus(1, 1, 0, 1, 32'h300);
    checkOutput("t6_count", 32'(fifo_count), 32'd0);
    checkOutput("t6_valid", 32'(instr_valid), 32'd0);
    checkOutput("t6_addr", imem_addr, 32'h0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("t6_idle_addr", imem_addr, 32'h0);
    applyStimulus(0, 1, 1, 0, 0);
    checkOutput("t6_idle_latency", 32'(instr_valid), 32'd0);
    applyStimulus(0, 1, 1, 0, 0);
    checkOutput("t6_first_pc", instr_pc, 32'h0);
    checkOutput("t6_first_valid", 32'(instr_valid), 32'd1);

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
